// File: rtl/stage_memory.sv
// Memory stage of the vector pipeline: results either pass straight through to
// writeback or drive a lane-serial byte load/store against the data memory.
module stage_memory #(
  parameter int vecSize   = 4,
  parameter int regSize   = 8,
  parameter int addrWidth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       validIn,
  input  logic [1:0]                 memOp,
  input  logic [addrWidth-1:0]       baseAddr,
  input  logic [vecSize*regSize-1:0] vectIn,
  input  logic [3:0]                 rdAddrIn,
  input  logic                       regWrEnIn,
  output logic                       stall,
  output logic                       validOut,
  output logic [vecSize*regSize-1:0] vectOut,
  output logic [3:0]                 rdAddrOut,
  output logic                       regWrEnOut,
  output logic                       memReq,
  output logic                       memWe,
  output logic [addrWidth-1:0]       memAddr,
  output logic [regSize-1:0]         memWrData,
  input  logic [regSize-1:0]         memRdData,
  input  logic                       memAck
);

  localparam int laneWidth = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [laneWidth-1:0] lastLane = laneWidth'(vecSize - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                     state_q, state_d;
  logic [laneWidth-1:0]       lane_q, lane_d;
  logic [addrWidth-1:0]       base_q, base_d;
  logic [vecSize*regSize-1:0] vec_q, vec_d;
  logic [3:0]                 rd_q, rd_d;
  logic                       wr_en_q, wr_en_d;
  logic                       is_store_q, is_store_d;
  logic                       valid_out_q, valid_out_d;
  logic [vecSize*regSize-1:0] vect_out_q, vect_out_d;
  logic [3:0]                 rd_out_q, rd_out_d;
  logic                       reg_wr_en_out_q, reg_wr_en_out_d;
  logic                       stall_c;
  logic                       is_mem_op;

  assign is_mem_op = (memOp == 2'b01) || (memOp == 2'b10);

  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    base_d          = base_q;
    vec_d           = vec_q;
    rd_d            = rd_q;
    wr_en_d         = wr_en_q;
    is_store_d      = is_store_q;
    valid_out_d     = 1'b0;
    vect_out_d      = vect_out_q;
    rd_out_d        = rd_out_q;
    reg_wr_en_out_d = reg_wr_en_out_q;
    stall_c         = 1'b0;
    memReq          = 1'b0;
    memWe           = 1'b0;
    memAddr         = '0;
    memWrData       = '0;

    case (state_q)
      IDLE: begin
        if (validIn) begin
          if (is_mem_op) begin
            state_d    = ACCESS;
            lane_d     = '0;
            base_d     = baseAddr;
            vec_d      = vectIn;
            rd_d       = rdAddrIn;
            wr_en_d    = regWrEnIn;
            is_store_d = (memOp == 2'b10);
            stall_c    = 1'b1;
          end else begin
            valid_out_d     = 1'b1;
            vect_out_d      = vectIn;
            rd_out_d        = rdAddrIn;
            reg_wr_en_out_d = regWrEnIn;
          end
        end
      end
      ACCESS: begin
        memReq    = 1'b1;
        memWe     = is_store_q;
        memAddr   = base_q + addrWidth'(lane_q);
        memWrData = vec_q[lane_q*regSize +: regSize];
        stall_c   = !(memAck && (lane_q == lastLane));
        if (memAck) begin
          // Loads overwrite the captured lane in place, so vec_q ends up holding the result.
          if (!is_store_q) begin
            vec_d[lane_q*regSize +: regSize] = memRdData;
          end
          lane_d = lane_q + 1'b1;
          if (lane_q == lastLane) begin
            state_d         = IDLE;
            lane_d          = '0;
            valid_out_d     = 1'b1;
            vect_out_d      = vec_d;
            rd_out_d        = rd_q;
            reg_wr_en_out_d = wr_en_q && !is_store_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      lane_q          <= '0;
      base_q          <= '0;
      vec_q           <= '0;
      rd_q            <= '0;
      wr_en_q         <= 1'b0;
      is_store_q      <= 1'b0;
      valid_out_q     <= 1'b0;
      vect_out_q      <= '0;
      rd_out_q        <= '0;
      reg_wr_en_out_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lane_q          <= lane_d;
      base_q          <= base_d;
      vec_q           <= vec_d;
      rd_q            <= rd_d;
      wr_en_q         <= wr_en_d;
      is_store_q      <= is_store_d;
      valid_out_q     <= valid_out_d;
      vect_out_q      <= vect_out_d;
      rd_out_q        <= rd_out_d;
      reg_wr_en_out_q <= reg_wr_en_out_d;
    end
  end

  // Stall is combinational from validIn, so it is gated to stay low during reset.
  assign stall      = stall_c && !rst;
  assign validOut   = valid_out_q;
  assign vectOut    = vect_out_q;
  assign rdAddrOut  = rd_out_q;
  assign regWrEnOut = reg_wr_en_out_q;

endmodule
